// File: rtl/div_ctrl.sv
// EX-stage issue/completion controller for the iterative divider: latches operands, holds start until ready, writes HI/LO.
// Latency: set by div_ready_i (stall covers request + BUSY); flush cancels with a 3-cycle start-low guard before the next issue.
module div_ctrl (
   input  logic        clk,
   input  logic        resetn,
   input  logic        div_req_i,
   input  logic        div_signed_i,
   input  logic [31:0] div_op1_i,
   input  logic [31:0] div_op2_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        div_start_o,
   output logic        div_annul_o,
   output logic        div_signed_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   input  logic [63:0] div_result_i,
   input  logic        div_ready_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        hilo_we_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, CANCEL} state_t;

   state_t     state_q, state_d;
   logic [1:0] guard_q, guard_d;
   logic       start_d;
   logic       annul_d;
   logic       load_ops;
   logic       capture;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= IDLE;
         guard_q      <= 2'd0;
         div_start_o  <= 1'b0;
         div_annul_o  <= 1'b0;
         div_signed_o <= 1'b0;
         div_op1_o    <= 32'd0;
         div_op2_o    <= 32'd0;
         hi_o         <= 32'd0;
         lo_o         <= 32'd0;
      end else begin
         state_q     <= state_d;
         guard_q     <= guard_d;
         div_start_o <= start_d;
         div_annul_o <= annul_d;
         if (load_ops) begin
            div_signed_o <= div_signed_i;
            div_op1_o    <= div_op1_i;
            div_op2_o    <= div_op2_i;
         end
         if (capture) begin
            hi_o <= div_result_i[63:32];
            lo_o <= div_result_i[31:0];
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      guard_d   = guard_q;
      start_d   = div_start_o;
      annul_d   = 1'b0;
      load_ops  = 1'b0;
      capture   = 1'b0;
      stall_o   = 1'b0;
      hilo_we_o = 1'b0;
      case (state_q)
         IDLE: begin
            stall_o = div_req_i & ~flush_i;
            if (div_req_i && !flush_i) begin
               load_ops = 1'b1;
               start_d  = 1'b1;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            stall_o = 1'b1;
            // flush wins over a same-cycle ready: the result is dropped
            if (flush_i) begin
               start_d = 1'b0;
               annul_d = 1'b1;
               guard_d = 2'd2;
               state_d = CANCEL;
            end else if (div_ready_i) begin
               capture = 1'b1;
               start_d = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            hilo_we_o = ~flush_i;
            state_d   = IDLE;
         end
         CANCEL: begin
            // annul alone may be ignored by the divider; the start-low window is what frees it
            stall_o = div_req_i;
            start_d = 1'b0;
            if (guard_q == 2'd0) state_d = IDLE;
            else                 guard_d = guard_q - 2'd1;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Randomized bench for div_ctrl with a cycle-timeline reference model and a simple divider model.
module tb_div_ctrl;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        div_req_i = 1'b0;
   logic        div_signed_i = 1'b0;
   logic [31:0] div_op1_i = 32'd0;
   logic [31:0] div_op2_i = 32'd0;
   logic        flush_i = 1'b0;
   logic        stall_o, div_start_o, div_annul_o, div_signed_o, hilo_we_o;
   logic [31:0] div_op1_o, div_op2_o, hi_o, lo_o;
   logic [63:0] div_result_i;
   logic        div_ready_i;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   div_ctrl dut (
      .clk(clk), .resetn(resetn), .div_req_i(div_req_i), .div_signed_i(div_signed_i),
      .div_op1_i(div_op1_i), .div_op2_i(div_op2_i), .flush_i(flush_i), .stall_o(stall_o),
      .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
      .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .div_result_i(div_result_i),
      .div_ready_i(div_ready_i), .hi_o(hi_o), .lo_o(lo_o), .hilo_we_o(hilo_we_o)
   );

   function automatic logic [63:0] mdiv(input logic sg, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] q, r;
      if (b == 32'd0) return 64'd0;
      if (sg) begin
         q = $signed(a) / $signed(b);
         r = $signed(a) % $signed(b);
      end else begin
         q = a / b;
         r = a % b;
      end
      return {r, q};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Divider: ready in the 36th start-high cycle (4th for a zero divisor)
   logic [5:0] dcnt;
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)          dcnt <= 6'd0;
      else if (div_start_o) dcnt <= dcnt + 6'd1;
      else                  dcnt <= 6'd0;
   end
   assign div_ready_i  = div_start_o && (dcnt == ((div_op2_o == 32'd0) ? 6'd3 : 6'd35));
   assign div_result_i = div_ready_i ? mdiv(div_signed_o, div_op1_o, div_op2_o) : 64'hA5A5_5A5A_0F0F_F0F0;

   // Reference timeline: accept at cycle a, BUSY a+1..a+L, DONE a+L+1; a flush in BUSY at c bars accepts until c+4
   int          c = 0;
   bit          m_act = 0;
   int          m_a = 0, m_L = 0, m_free = 0, m_annul_c = -10;
   logic        m_sg = 1'b0;
   logic [31:0] m_op1 = 32'd0, m_op2 = 32'd0, m_hi = 32'd0, m_lo = 32'd0;

   always @(negedge clk) begin
      bit          e_stall, e_we, e_start, e_annul, cap;
      logic [63:0] r;
      if (!resetn) begin
         m_act = 0; m_free = 0; m_annul_c = -10; m_hi = 32'd0; m_lo = 32'd0;
      end else begin
         e_start = m_act && (c > m_a) && (c <= m_a + m_L);
         e_annul = (c == m_annul_c);
         e_stall = 0; e_we = 0; cap = 0;
         if (m_act && c <= m_a + m_L) begin
            e_stall = 1;
            if (flush_i) begin
               m_act = 0; m_annul_c = c + 1; m_free = c + 4;
            end else if (c == m_a + m_L) cap = 1;
         end else if (m_act) begin
            e_we = !flush_i; m_act = 0; m_free = c + 1;
         end else if (c < m_free) begin
            e_stall = div_req_i;
         end else begin
            e_stall = div_req_i && !flush_i;
            if (e_stall) begin
               m_act = 1; m_a = c; m_sg = div_signed_i; m_op1 = div_op1_i; m_op2 = div_op2_i;
               m_L = (div_op2_i != 32'd0) ? 36 : 4;
            end
         end
         check("stall_o", stall_o, e_stall);
         check("hilo_we_o", hilo_we_o, e_we);
         check("div_start_o", div_start_o, e_start);
         check("div_annul_o", div_annul_o, e_annul);
         check("hi_o", hi_o, m_hi);
         check("lo_o", lo_o, m_lo);
         if (e_start) begin
            check("div_op1_o", div_op1_o, m_op1);
            check("div_op2_o", div_op2_o, m_op2);
            check("div_signed_o", div_signed_o, m_sg);
         end
         if (cap) begin
            r = mdiv(m_sg, m_op1, m_op2);
            m_hi = r[63:32]; m_lo = r[31:0];
         end
      end
      c++;
   end

   // Holds one instruction in EX until it leaves (stall low) or is flushed; n counts cycles from its first cycle.
   task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b, input int flush_at,
                         input bit f_rdy, input bit f_done, output int n_done, output int n_start,
                         output int n_we, output int n_annul);
      int n = 0;
      bit prev = 0, fin = 0;
      n_done = -1; n_start = 0; n_we = 0; n_annul = 0;
      while (!fin && n < 300) begin
         @(posedge clk); #1;
         div_req_i = 1'b1; div_signed_i = sg; div_op1_i = a; div_op2_i = b;
         flush_i = (n == flush_at) || (f_rdy && div_ready_i) || (f_done && prev);
         prev = div_ready_i;
         #1;
         n_start += int'(div_start_o);
         n_we    += int'(hilo_we_o);
         n_annul += int'(div_annul_o);
         if (!stall_o || flush_i) begin
            fin = 1; n_done = n;
         end
         n++;
      end
      if (!fin) begin
         n_checks++; n_fail++;
         $display("FAIL div_timeout: got no completion in %0d cycles, required completion", n);
      end
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(posedge clk); #1;
         div_req_i = 1'b0;
         flush_i   = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
      flush_i = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, required finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int nd, ns, nw, na;
      logic sg;
      logic [31:0] a, b;
      int fa;

      #12;
      check("rst_start", div_start_o, 0);
      check("rst_annul", div_annul_o, 0);
      check("rst_signed", div_signed_o, 0);
      check("rst_op1", div_op1_o, 0);
      check("rst_op2", div_op2_o, 0);
      check("rst_hilo", {hi_o, lo_o}, 0);
      check("rst_we", hilo_we_o, 0);
      check("rst_stall_noreq", stall_o, 0);
      div_req_i = 1'b1; #1;
      check("rst_stall_req", stall_o, 1);
      div_req_i = 1'b0;
      @(posedge clk); #1 resetn = 1'b1;
      idle(2);

      do_div(1'b0, 32'd100, 32'd7, -1, 0, 0, nd, ns, nw, na);
      check("divu100_7_stall_cycles", nd, 37);
      check("divu100_7_start_cycles", ns, 36);
      check("divu100_7_we", nw, 1);
      check("divu100_7_hi", hi_o, 32'd2);
      check("divu100_7_lo", lo_o, 32'd14);

      do_div(1'b1, -32'sd7, 32'd2, -1, 0, 0, nd, ns, nw, na);
      check("div_m7_2_start_cycles", ns, 36);
      check("div_m7_2_hi", hi_o, 32'hFFFF_FFFF);
      check("div_m7_2_lo", lo_o, 32'hFFFF_FFFD);

      do_div(1'b0, 32'd5, 32'd0, -1, 0, 0, nd, ns, nw, na);
      check("div0_stall_cycles", nd, 5);
      check("div0_we", nw, 1);
      check("div0_hilo", {hi_o, lo_o}, 64'd0);

      do_div(1'b0, 32'd1000, 32'd3, 10, 0, 0, nd, ns, nw, na);
      check("cancel_we", nw, 0);
      do_div(1'b0, 32'd9, 32'd3, -1, 0, 0, nd, ns, nw, na);
      check("after_cancel_annul", na, 1);
      check("after_cancel_cycles", nd, 40);
      check("divu9_3_hi", hi_o, 32'd0);
      check("divu9_3_lo", lo_o, 32'd3);

      do_div(1'b0, 32'd50, 32'd5, -1, 1, 0, nd, ns, nw, na);
      check("flush_ready_we", nw, 0);
      check("flush_ready_hi", hi_o, 32'd0);
      check("flush_ready_lo", lo_o, 32'd3);

      do_div(1'b0, 32'd50, 32'd5, -1, 0, 1, nd, ns, nw, na);
      check("flush_done_we", nw, 0);
      check("flush_done_lo", lo_o, 32'd10);

      for (int i = 0; i < 50; i++) begin
         sg = 1'($urandom_range(0, 1));
         a  = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1, 2:    b = $urandom_range(1, 20);
            3:       b = -$urandom_range(1, 20);
            default: b = $urandom;
         endcase
         if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
         do_div(sg, a, b, fa, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0), nd, ns, nw, na);
         if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 2));
      end

      idle(5);
      @(posedge clk); #1;
      div_req_i = 1'b1; div_signed_i = 1'b1; div_op1_i = 32'd77; div_op2_i = 32'd5;
      repeat (5) @(posedge clk);
      #3;
      resetn = 1'b0; div_req_i = 1'b0; flush_i = 1'b0;
      #1;
      check("midrst_start", div_start_o, 0);
      check("midrst_annul", div_annul_o, 0);
      check("midrst_signed", div_signed_o, 0);
      check("midrst_op1", div_op1_o, 0);
      check("midrst_op2", div_op2_o, 0);
      check("midrst_hilo", {hi_o, lo_o}, 0);
      check("midrst_we", hilo_we_o, 0);
      check("midrst_stall", stall_o, 0);
      @(posedge clk); #1 resetn = 1'b1;
      do_div(1'b0, 32'd1, 32'd1, -1, 0, 0, nd, ns, nw, na);
      check("after_rst_we", nw, 1);
      check("after_rst_hi", hi_o, 32'd0);
      check("after_rst_lo", lo_o, 32'd1);
      idle(3);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Execute-stage issue and completion controller for the iterative 32-bit divider. It accepts a DIV/DIVU request from the EX stage and drives the divider's start/annul/signed/operand inputs. It stalls the pipeline until the divider reports ready, then captures the 64-bit result and issues a one-cycle HI/LO write. On a pipeline flush it cancels the division and guards the divider back to its free state before accepting a new request.

## Interface
- No parameters; datapath fixed at 32-bit operands, 64-bit result.
- clk  in  1  system clock, all state on rising edge
- resetn  in  1  reset, asynchronous, active-low
- div_req_i  in  1  EX stage holds a DIV/DIVU; level, held while stall_o=1
- div_signed_i  in  1  1=DIV, 0=DIVU; valid with div_req_i
- div_op1_i  in  32  dividend (rs)
- div_op2_i  in  32  divisor (rt)
- flush_i  in  1  pipeline flush (exception/eret); kills the EX instruction
- stall_o  out  1  combinational stall request to pipeline control
- div_start_o  out  1  divider start, registered
- div_annul_o  out  1  divider annul, registered
- div_signed_o  out  1  divider signed-mode, registered, stable while start=1
- div_op1_o  out  32  divider dividend, registered
- div_op2_o  out  32  divider divisor, registered
- div_result_i  in  64  {remainder, quotient} from divider
- div_ready_i  in  1  divider result valid
- hi_o  out  32  captured remainder
- lo_o  out  32  captured quotient
- hilo_we_o  out  1  one-cycle HI/LO write strobe

## Operation
- States: IDLE, BUSY, DONE, CANCEL (guard counter 2 bits).
- IDLE: div_req_i=1 and flush_i=0 -> latch operands/signed into div_op*_o/div_signed_o, start<=1, -> BUSY. div_req_i=1 and flush_i=1 -> stay IDLE, no start.
- BUSY: start held 1, operands and signed held constant. flush_i=1 -> start<=0, annul<=1, guard<=2, -> CANCEL (flush has priority over ready in the same cycle). Otherwise div_ready_i=1 -> hi_o<=div_result_i[63:32], lo_o<=div_result_i[31:0], start<=0, -> DONE.
- DONE: one cycle; hilo_we_o=1 unless flush_i=1 (write suppressed, still -> IDLE). The divider sees start=0 and returns free by the end of this cycle. -> IDLE.
- CANCEL: annul=1 for the first cycle only; start=0 throughout. Guard counts down 2 cycles after annul, so start stays low for 3 cycles total, which covers the divide-by-zero path (01->11->00). -> IDLE when guard=0. A new request here is stalled, not started.
- stall_o = (IDLE & div_req_i & ~flush_i) | BUSY | (CANCEL & div_req_i). Low in DONE.
- Divider contract: start held until ready observed; signed held for the whole operation; annul only honoured while the divider iterates, so controller never relies on annul alone.
- div_ready_i outside BUSY is ignored. hi_o/lo_o hold their last value until the next capture.

## Timing
- Reset (async assert, sync release): state=IDLE, guard=0, div_start_o=0, div_annul_o=0, div_signed_o=0, div_op1_o=div_op2_o=0, hi_o=lo_o=0, hilo_we_o=0. stall_o follows its equation (IDLE term only).
- Reset mid-BUSY: immediate IDLE. The divider shares resetn and also clears.
- With the team divider: nonzero divisor -> div_ready_i first high in BUSY cycle 36, so stall_o is high for 37 cycles (request cycle + 36 BUSY) and hilo_we_o fires in cycle 38. Divisor 0 -> ready in BUSY cycle 4, result 0, hilo_we_o in cycle 6.
- The controller does not count iterations; latency is set by div_ready_i alone.
- Back-to-back DIVs: second start is asserted one cycle after DONE (IDLE request cycle), never while the divider is in DivEnd.

## Test plan
- DIVU 100/7: start high 36 cycles, hilo_we_o=1 in cycle 38 with hi_o=2, lo_o=14; stall_o low exactly in the DONE cycle.
- DIV -7/2 signed: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD; div_signed_o=1 and div_op*_o stable throughout BUSY.
- Divide by zero (5/0): ready in BUSY cycle 4, hi_o=lo_o=0, hilo_we_o pulses once.
- flush_i at BUSY cycle 10: annul high 1 cycle, start low ≥3 cycles, no hilo_we_o; a new DIVU 9/3 issued during CANCEL stalls, then completes with lo_o=3, hi_o=0.
- flush_i in the same cycle as div_ready_i, and flush_i in DONE: hilo_we_o stays 0 and hi_o/lo_o are unchanged in the first case.
- resetn asserted mid-BUSY: all outputs take reset values asynchronously; after release, DIVU 1/1 completes normally with lo_o=1.
